// File: rtl/nim_input_pkg.sv
// Shared defaults and the per-channel configuration record for the NIM input bank.
// Definitions only: no latency and no backpressure apply.
package nim_input_pkg;

    localparam int N_CH_DEF      = 4;
    localparam int DELAY_W_DEF   = 7;
    localparam int STRETCH_W_DEF = 8;
    localparam int PAT_W_DEF     = 8;
    localparam int CNT_W_DEF     = 32;

    typedef struct packed {
        logic [DELAY_W_DEF-1:0]   delay;
        logic [STRETCH_W_DEF-1:0] stretch;
        logic [STRETCH_W_DEF-1:0] holdoff;
        logic [PAT_W_DEF-1:0]     mask;
        logic [PAT_W_DEF-1:0]     pattern;
        logic                     invert;
    } chan_cfg_t;

endpackage

// File: rtl/nim_input_chan.sv
// One NIM channel: pattern match, retriggerable stretch, holdoff, tap delay and a saturating count.
// Config is used one cycle after it changes; free-running, with no backpressure.
module nim_input_chan
    import nim_input_pkg::*;
#(
    parameter int DELAY_W   = DELAY_W_DEF,
    parameter int STRETCH_W = STRETCH_W_DEF,
    parameter int PAT_W     = PAT_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_trig,
    input  logic                 i_invert,
    input  logic [DELAY_W-1:0]   i_delay,
    input  logic [STRETCH_W-1:0] i_stretch,
    input  logic [STRETCH_W-1:0] i_holdoff,
    input  logic [PAT_W-1:0]     i_mask,
    input  logic [PAT_W-1:0]     i_pattern,
    input  logic                 i_reset_cnt,
    output logic                 o_trig,
    output logic [CNT_W-1:0]     o_count
);

    localparam int               DLINE_LEN = 2**DELAY_W;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic                 r_invert_z;
    logic [DELAY_W-1:0]   r_delay_z;
    logic [STRETCH_W-1:0] r_stretch_z;
    logic [STRETCH_W-1:0] r_holdoff_z;
    logic [PAT_W-1:0]     r_mask_z;
    logic [PAT_W-1:0]     r_pattern_z;

    logic [PAT_W-1:0]     r_hist;
    logic [STRETCH_W-1:0] r_scnt;
    logic [STRETCH_W-1:0] r_hcnt;
    logic [CNT_W-1:0]     r_count;
    logic [DLINE_LEN-1:0] r_dline;

    logic                 w_pol;
    logic                 w_match;
    logic                 w_accept;
    logic                 w_pre;
    logic [DELAY_W-1:0]   w_tap;

    assign w_pol    = i_trig ^ r_invert_z;
    // Unmasked history bits are forced to "equal", so an all-zero mask always matches.
    assign w_match  = ((r_hist ~^ r_pattern_z) & r_mask_z) == r_mask_z;
    assign w_accept = w_match && (r_hcnt == '0);
    assign w_pre    = (r_stretch_z == '0) ? r_hist[0] : (r_scnt != '0);

    // Tap k of the line holds pre from k+1 cycles ago; retargeting the tap never flushes it.
    assign w_tap    = r_delay_z - DELAY_W'(1);
    assign o_trig   = (r_delay_z == '0) ? w_pre : r_dline[w_tap];
    assign o_count  = r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_invert_z  <= 1'b0;
            r_delay_z   <= '0;
            r_stretch_z <= '0;
            r_holdoff_z <= '0;
            r_mask_z    <= '0;
            r_pattern_z <= '0;
            r_hist      <= '0;
            r_scnt      <= '0;
            r_hcnt      <= '0;
            r_count     <= '0;
            r_dline     <= '0;
        end else begin
            r_invert_z  <= i_invert;
            r_delay_z   <= i_delay;
            r_stretch_z <= i_stretch;
            r_holdoff_z <= i_holdoff;
            r_mask_z    <= i_mask;
            r_pattern_z <= i_pattern;

            r_hist  <= {r_hist[PAT_W-2:0], w_pol};
            r_dline <= {r_dline[DLINE_LEN-2:0], w_pre};

            if (w_accept) begin
                r_scnt <= r_stretch_z;
                r_hcnt <= r_holdoff_z;
            end else begin
                if (r_scnt != '0) r_scnt <= r_scnt - STRETCH_W'(1);
                if (r_hcnt != '0) r_hcnt <= r_hcnt - STRETCH_W'(1);
            end

            // A clear wins over a same-cycle acceptance.
            if (i_reset_cnt) begin
                r_count <= '0;
            end else if (w_accept && (r_count != CNT_MAX)) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nim_input_bank.sv
// Bank of N_CH conditioned NIM inputs; NIM_INPUT_BANK_COINC_EN adds registered AND/OR coincidence.
// trig_out follows pre after delay_z cycles, coincidence one cycle later; no backpressure.
module nim_input_bank
    import nim_input_pkg::*;
#(
    parameter int N_CH      = N_CH_DEF,
    parameter int DELAY_W   = DELAY_W_DEF,
    parameter int STRETCH_W = STRETCH_W_DEF,
    parameter int PAT_W     = PAT_W_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CH-1:0]           trig_in,
    input  logic [N_CH-1:0]           invert,
    input  logic [N_CH*DELAY_W-1:0]   delay,
    input  logic [N_CH*STRETCH_W-1:0] stretch,
    input  logic [N_CH*STRETCH_W-1:0] holdoff,
    input  logic [N_CH*PAT_W-1:0]     mask,
    input  logic [N_CH*PAT_W-1:0]     pattern,
    input  logic [N_CH-1:0]           reset_cnt,
    output logic [N_CH-1:0]           trig_out,
    output logic [N_CH*CNT_W-1:0]     count,
    input  logic [N_CH-1:0]           coinc_mask,
    output logic                      coinc_and,
    output logic                      coinc_or
);

    logic [N_CH-1:0] w_trig_out;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        nim_input_chan #(
            .DELAY_W   (DELAY_W),
            .STRETCH_W (STRETCH_W),
            .PAT_W     (PAT_W),
            .CNT_W     (CNT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .i_trig      (trig_in[g]),
            .i_invert    (invert[g]),
            .i_delay     (delay[g*DELAY_W +: DELAY_W]),
            .i_stretch   (stretch[g*STRETCH_W +: STRETCH_W]),
            .i_holdoff   (holdoff[g*STRETCH_W +: STRETCH_W]),
            .i_mask      (mask[g*PAT_W +: PAT_W]),
            .i_pattern   (pattern[g*PAT_W +: PAT_W]),
            .i_reset_cnt (reset_cnt[g]),
            .o_trig      (w_trig_out[g]),
            .o_count     (count[g*CNT_W +: CNT_W])
        );
    end

    assign trig_out = w_trig_out;

`ifdef NIM_INPUT_BANK_COINC_EN
    logic [N_CH-1:0] r_coinc_mask_z;
    logic            r_coinc_and;
    logic            r_coinc_or;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_coinc_mask_z <= '0;
            r_coinc_and    <= 1'b0;
            r_coinc_or     <= 1'b0;
        end else begin
            r_coinc_mask_z <= coinc_mask;
            // An empty mask must not read as a vacuous AND.
            r_coinc_and    <= (r_coinc_mask_z != '0) &&
                              ((w_trig_out & r_coinc_mask_z) == r_coinc_mask_z);
            r_coinc_or     <= (w_trig_out & r_coinc_mask_z) != '0;
        end
    end

    assign coinc_and = r_coinc_and;
    assign coinc_or  = r_coinc_or;
`else
    logic w_unused_coinc;
    assign w_unused_coinc = ^coinc_mask;
    assign coinc_and      = 1'b0;
    assign coinc_or       = 1'b0;
`endif

endmodule

// File: tb/tb_nim_input_bank.sv
// Directed scenarios plus randomized traffic, checked every cycle against a time-indexed reference model.
module tb_nim_input_bank;
    import nim_input_pkg::*;

    localparam int N_CH      = 4;
    localparam int DELAY_W   = DELAY_W_DEF;
    localparam int STRETCH_W = STRETCH_W_DEF;
    localparam int PAT_W     = PAT_W_DEF;
    localparam int CNT_W     = 4;
    localparam int CNT_MAX   = 15;
    localparam int MAXT      = 2048;
`ifdef NIM_INPUT_BANK_COINC_EN
    localparam bit COINC = 1'b1;
`else
    localparam bit COINC = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    logic [N_CH-1:0]           trig_in;
    logic [N_CH-1:0]           invert;
    logic [N_CH*DELAY_W-1:0]   delay;
    logic [N_CH*STRETCH_W-1:0] stretch;
    logic [N_CH*STRETCH_W-1:0] holdoff;
    logic [N_CH*PAT_W-1:0]     mask;
    logic [N_CH*PAT_W-1:0]     pattern;
    logic [N_CH-1:0]           reset_cnt;
    logic [N_CH-1:0]           trig_out;
    logic [N_CH*CNT_W-1:0]     count;
    logic [N_CH-1:0]           coinc_mask;
    logic                      coinc_and;
    logic                      coinc_or;

    always #5 clk = ~clk;

    nim_input_bank #(
        .N_CH(N_CH), .DELAY_W(DELAY_W), .STRETCH_W(STRETCH_W), .PAT_W(PAT_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .trig_in(trig_in), .invert(invert),
        .delay(delay), .stretch(stretch), .holdoff(holdoff),
        .mask(mask), .pattern(pattern), .reset_cnt(reset_cnt),
        .trig_out(trig_out), .count(count),
        .coinc_mask(coinc_mask), .coinc_and(coinc_and), .coinc_or(coinc_or)
    );

    int n_vec = 0;
    int n_err = 0;

    // Applied configuration and the model's view of it.
    chan_cfg_t cfg [N_CH];
    chan_cfg_t m_z [N_CH];

    // Model: pol and pre recorded by clock edge number; anything at or before the last reset reads 0.
    bit              pol_log [N_CH][MAXT];
    bit              pre_log [N_CH][MAXT];
    int              t        = 0;
    int              last_rst = 0;
    int              m_scnt [N_CH];
    int              m_hcnt [N_CH];
    int              m_cnt  [N_CH];
    logic [N_CH-1:0] m_trig;
    logic [N_CH-1:0] m_cmask;
    logic            m_cand;
    logic            m_cor;

    function automatic bit pol_at(int c, int tt);
        if (tt <= last_rst) return 1'b0;
        return pol_log[c][tt];
    endfunction

    function automatic bit pre_at(int c, int tt);
        if (tt <= last_rst) return 1'b0;
        return pre_log[c][tt];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic [N_CH-1:0] old_trig;
        t++;
        if (t >= MAXT) begin
            $display("FAIL model_time: edge %0d exceeds budget %0d", t, MAXT);
            $fatal(1, "model time budget exceeded");
        end
        if (reset) begin
            last_rst = t;
            for (int c = 0; c < N_CH; c++) begin
                m_z[c] = '0; m_scnt[c] = 0; m_hcnt[c] = 0; m_cnt[c] = 0;
            end
            m_trig = '0; m_cmask = '0; m_cand = 1'b0; m_cor = 1'b0;
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                bit match = 1'b1;
                bit acc;
                for (int i = 0; i < PAT_W; i++)
                    if (m_z[c].mask[i] && (pol_at(c, t-1-i) != m_z[c].pattern[i])) match = 1'b0;
                acc = match && (m_hcnt[c] == 0);
                if (reset_cnt[c]) m_cnt[c] = 0;
                else if (acc && m_cnt[c] < CNT_MAX) m_cnt[c]++;
                if (acc) begin
                    m_scnt[c] = int'(m_z[c].stretch);
                    m_hcnt[c] = int'(m_z[c].holdoff);
                end else begin
                    m_scnt[c] = (m_scnt[c] > 0) ? m_scnt[c] - 1 : 0;
                    m_hcnt[c] = (m_hcnt[c] > 0) ? m_hcnt[c] - 1 : 0;
                end
                pol_log[c][t] = trig_in[c] ^ m_z[c].invert;
            end
            old_trig = m_trig;
            if (COINC) begin
                m_cand = (m_cmask != '0) && ((old_trig & m_cmask) == m_cmask);
                m_cor  = (old_trig & m_cmask) != '0;
            end else begin
                m_cand = 1'b0;
                m_cor  = 1'b0;
            end
            m_cmask = coinc_mask;
            for (int c = 0; c < N_CH; c++) begin
                m_z[c] = cfg[c];
                pre_log[c][t] = (m_z[c].stretch == '0) ? pol_at(c, t) : (m_scnt[c] != 0);
                m_trig[c] = pre_at(c, t - int'(m_z[c].delay));
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("trig_out[%0d]@%0d", c, t), 32'(trig_out[c]), 32'(m_trig[c]));
            chk($sformatf("count[%0d]@%0d", c, t), 32'(count[c*CNT_W +: CNT_W]), 32'(m_cnt[c]));
        end
        chk($sformatf("coinc_and@%0d", t), 32'(coinc_and), 32'(m_cand));
        chk($sformatf("coinc_or@%0d", t), 32'(coinc_or), 32'(m_cor));
    endtask

    task automatic tick();
        for (int c = 0; c < N_CH; c++) begin
            invert[c]                      = cfg[c].invert;
            delay[c*DELAY_W +: DELAY_W]     = cfg[c].delay;
            stretch[c*STRETCH_W +: STRETCH_W] = cfg[c].stretch;
            holdoff[c*STRETCH_W +: STRETCH_W] = cfg[c].holdoff;
            mask[c*PAT_W +: PAT_W]          = cfg[c].mask;
            pattern[c*PAT_W +: PAT_W]       = cfg[c].pattern;
        end
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic set_cfg(input int c, input logic [DELAY_W-1:0] d, input logic [STRETCH_W-1:0] s,
                           input logic [STRETCH_W-1:0] h, input logic [PAT_W-1:0] m,
                           input logic [PAT_W-1:0] p);
        cfg[c].delay = d; cfg[c].stretch = s; cfg[c].holdoff = h;
        cfg[c].mask = m; cfg[c].pattern = p; cfg[c].invert = 1'b0;
    endtask

    task automatic settle();
        trig_in = '0;
        repeat (3) tick();
        reset_cnt = '1;
        tick();
        reset_cnt = '0;
        repeat (12) tick();
    endtask

    bit w0 [64];
    bit w1 [64];
    int hi_cnt, first_hi, n_rise, and_cnt, or_cnt;

    task automatic clr_waves();
        for (int i = 0; i < 64; i++) begin w0[i] = 1'b0; w1[i] = 1'b0; end
    endtask

    task automatic set_pulse(input int c, input int start, input int len);
        for (int i = start; i < start + len; i++) begin
            if (c == 0) w0[i] = 1'b1; else w1[i] = 1'b1;
        end
    endtask

    task automatic run_wave(input int n);
        bit prev = 1'b0;
        hi_cnt = 0; first_hi = -1; n_rise = 0; and_cnt = 0; or_cnt = 0;
        for (int i = 0; i < n; i++) begin
            trig_in[0] = w0[i];
            trig_in[1] = w1[i];
            tick();
            if (trig_out[0]) begin
                hi_cnt++;
                if (first_hi < 0) first_hi = i;
            end
            if (trig_out[0] && !prev) n_rise++;
            prev = trig_out[0];
            if (coinc_and) and_cnt++;
            if (coinc_or) or_cnt++;
        end
        trig_in = '0;
    endtask

    initial begin
        reset = 1'b1; trig_in = '0; reset_cnt = '0; coinc_mask = '0;
        for (int c = 0; c < N_CH; c++) set_cfg(c, 7'd0, 8'd0, 8'd0, 8'h01, 8'h01);
        repeat (3) tick();
        chk("reset_trig_out", 32'(trig_out), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_coinc", 32'({coinc_and, coinc_or}), 32'd0);
        reset = 1'b0;

        // Single-cycle pulse, no stretch or delay.
        set_cfg(0, 7'd0, 8'd0, 8'd0, 8'h01, 8'h01);
        settle(); clr_waves(); set_pulse(0, 0, 1); run_wave(8);
        chk("A_len", 32'(hi_cnt), 32'd1);
        chk("A_start", 32'(first_hi), 32'd0);
        chk("A_count", 32'(count[CNT_W-1:0]), 32'd1);

        // Rising-edge match, stretch 5, delay 10: pre rises at cycle 1, output at 11.
        set_cfg(0, 7'd10, 8'd5, 8'd0, 8'h03, 8'h01);
        settle(); clr_waves(); set_pulse(0, 0, 20); run_wave(40);
        chk("B_len", 32'(hi_cnt), 32'd5);
        chk("B_start", 32'(first_hi), 32'd11);
        chk("B_pulses", 32'(n_rise), 32'd1);
        chk("B_count", 32'(count[CNT_W-1:0]), 32'd1);

        // Two edges two cycles apart merge into one 6-cycle pulse.
        set_cfg(0, 7'd0, 8'd4, 8'd0, 8'h03, 8'h01);
        settle(); clr_waves(); set_pulse(0, 0, 1); set_pulse(0, 2, 1); run_wave(16);
        chk("C_len", 32'(hi_cnt), 32'd6);
        chk("C_pulses", 32'(n_rise), 32'd1);
        chk("C_count", 32'(count[CNT_W-1:0]), 32'd2);

        // Holdoff 20 rejects an edge 10 cycles later.
        set_cfg(0, 7'd0, 8'd2, 8'd20, 8'h03, 8'h01);
        settle(); clr_waves(); set_pulse(0, 0, 1); set_pulse(0, 10, 1); run_wave(30);
        chk("D_len", 32'(hi_cnt), 32'd2);
        chk("D_count", 32'(count[CNT_W-1:0]), 32'd1);

        // 17 edges saturate a 4-bit count, then a clear coinciding with acceptance wins.
        set_cfg(0, 7'd0, 8'd1, 8'd0, 8'h03, 8'h01);
        settle(); clr_waves();
        for (int k = 0; k < 17; k++) set_pulse(0, 2*k, 1);
        run_wave(40);
        chk("E_saturate", 32'(count[CNT_W-1:0]), 32'd15);
        trig_in[0] = 1'b1; tick();
        trig_in[0] = 1'b0; reset_cnt[0] = 1'b1; tick();
        reset_cnt[0] = 1'b0;
        chk("E_clear_vs_accept", 32'(count[CNT_W-1:0]), 32'd0);
        tick();
        chk("E_clear_hold", 32'(count[CNT_W-1:0]), 32'd0);

        // Coincidence of ch0/ch1 overlapping for 3 cycles.
        set_cfg(0, 7'd0, 8'd0, 8'd0, 8'h01, 8'h01);
        set_cfg(1, 7'd0, 8'd0, 8'd0, 8'h01, 8'h01);
        coinc_mask = 4'h3;
        settle(); clr_waves(); set_pulse(0, 0, 5); set_pulse(1, 2, 5); run_wave(12);
        chk("F_and_len", 32'(and_cnt), COINC ? 32'd3 : 32'd0);
        chk("F_or_len", 32'(or_cnt), COINC ? 32'd7 : 32'd0);

        // Reset in the middle of a stretched pulse.
        set_cfg(0, 7'd0, 8'd8, 8'd0, 8'h03, 8'h01);
        settle();
        trig_in[0] = 1'b1; tick();
        trig_in[0] = 1'b0; repeat (3) tick();
        chk("G_mid_pulse", 32'(trig_out[0]), 32'd1);
        chk("G_mid_or", 32'(coinc_or), COINC ? 32'd1 : 32'd0);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("G_reset_trig", 32'(trig_out), 32'd0);
        chk("G_reset_coinc", 32'({coinc_and, coinc_or}), 32'd0);
        chk("G_reset_count", 32'(count), 32'd0);

        // Randomized traffic and configuration churn, including mid-pulse delay changes.
        for (int n = 0; n < 500; n++) begin
            trig_in   = N_CH'($urandom);
            reset_cnt = '0;
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 15) == 0) reset_cnt[c] = 1'b1;
                if ($urandom_range(0, 19) == 0) begin
                    cfg[c].delay   = DELAY_W'($urandom_range(0, 15));
                    cfg[c].stretch = STRETCH_W'($urandom_range(0, 6));
                    cfg[c].holdoff = STRETCH_W'($urandom_range(0, 8));
                    cfg[c].mask    = PAT_W'($urandom_range(0, 15));
                    cfg[c].pattern = PAT_W'($urandom);
                    cfg[c].invert  = 1'($urandom);
                end
            end
            if ($urandom_range(0, 31) == 0) coinc_mask = N_CH'($urandom);
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 1'b0; reset_cnt = '0; trig_in = '0;
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/nim_input_bank.md
NIM_INPUT_BANK -- requirements
Module: nim_input_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of independent NIM input channels.
REQ-002 SHALL have parameter DELAY_W, default 7, delay setting width (0..2^DELAY_W-1 cycles).
REQ-003 SHALL have parameter STRETCH_W, default 8, stretch and holdoff setting width.
REQ-004 SHALL have parameter PAT_W, default 8, pattern history depth.
REQ-005 SHALL have parameter CNT_W, default 32, trigger counter width.
REQ-006 SHALL have ports: clk  in  1  clock; reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports: trig_in  in  N_CH  raw NIM inputs; invert  in  N_CH  per-channel polarity flip.
REQ-008 SHALL have ports: delay  in  N_CH*DELAY_W; stretch  in  N_CH*STRETCH_W; holdoff  in  N_CH*STRETCH_W.
REQ-009 SHALL have ports: mask  in  N_CH*PAT_W; pattern  in  N_CH*PAT_W; reset_cnt  in  N_CH  per-channel counter clear.
REQ-010 SHALL have ports: trig_out  out  N_CH  conditioned outputs; count  out  N_CH*CNT_W  accepted-trigger counts.
REQ-011 SHALL have ports: coinc_mask  in  N_CH; coinc_and  out  1; coinc_or  out  1.

Function
REQ-012 All configuration inputs SHALL be registered once (_z copies) before use; changes take effect one cycle later.
REQ-013 Per channel, pol = trig_in ^ invert_z; hist SHALL shift left each cycle with pol entering bit 0.
REQ-014 match SHALL be true when every bit i with mask_z[i]=1 satisfies hist[i]==pattern_z[i]; mask_z=0 means match is always true.
REQ-015 A trigger SHALL be accepted when match is true and holdoff counter hcnt==0.
REQ-016 On acceptance: scnt <= stretch_z, hcnt <= holdoff_z, count += 1; otherwise nonzero scnt and hcnt each decrement by 1.
REQ-017 Acceptance while scnt nonzero SHALL reload scnt (retrigger extends the pulse).
REQ-018 pre SHALL be hist[0] when stretch_z==0, else the registered flag (scnt != 0).
REQ-019 trig_out SHALL equal pre delayed by delay_z cycles; delay_z==0 passes pre directly.
REQ-020 count SHALL saturate at all-ones, never wrap.
REQ-021 reset_cnt SHALL clear count; simultaneous reset_cnt and acceptance SHALL yield count=0.
REQ-022 A delay_z change mid-pulse SHALL re-tap the existing delay line, with no flush.

Reset
REQ-023 reset SHALL clear hist, scnt, hcnt, count, the delay line and the _z registers; trig_out, coinc_and and coinc_or SHALL be 0 on the cycle after reset.
REQ-024 reset asserted mid-stretch SHALL terminate the pulse; the output SHALL be 0 on the next cycle.

Configuration
REQ-025 Macro NIM_INPUT_BANK_COINC_EN: defined -> coinc_and is registered AND over trig_out of channels with coinc_mask_z=1, and coinc_or is registered OR over them. An all-zero mask SHALL give coinc_and=0 and coinc_or=0.
REQ-026 Macro undefined -> coinc_and and coinc_or SHALL be tied 0, and coinc_mask SHALL be unused with no logic inferred.

Structure
REQ-027 Package nim_input_pkg SHALL hold the default parameter constants and a typedef for the per-channel config struct (delay, stretch, holdoff, mask, pattern, invert).
REQ-028 Sub-module nim_input_chan SHALL implement one channel (REQ-013..REQ-024). The top SHALL generate N_CH instances and contain the coincidence logic.

Verification
REQ-029 Bench scenario: stretch=0, delay=0, mask=0x01, pattern=0x01, 1-cycle input pulse -> 1-cycle trig_out, with count incrementing by 1.
REQ-030 Bench scenario: stretch=5, delay=10, mask=0x03, pattern=0x01 (rising edge), 20-cycle input -> exactly 5-cycle trig_out starting 10 cycles after pre rises; count=1.
REQ-031 Bench scenario: stretch=4, holdoff=0, two edges 2 cycles apart -> one merged pulse, 6 cycles long; count=2.
REQ-032 Bench scenario: holdoff=20, edges at t and t+10 -> second edge rejected; count=1.
REQ-033 Bench scenario: CNT_W=4, 17 edges -> count holds 15; then reset_cnt asserted together with an edge -> count=0.
REQ-034 Bench scenario (COINC_EN): coinc_mask=0x3, ch0 and ch1 overlapping for 3 cycles -> coinc_and high for 3 cycles; reset asserted mid-pulse -> all outputs 0 on the next cycle.
